// File: rtl/easy_axi_rd_mst_if.sv
// AXI read-address and read-data channels shared by the read master and its slave.
interface easy_axi_rd_mst_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/easy_axi_rd_mst.sv
// Simple AXI read master: issues cfg_num INCR bursts of cfg_len+1 beats from
// cfg_base, keeps at most MAX_OST in flight, checks every returned beat against
// the burst it belongs to and forwards accepted data to a one-cycle-late sink.
module easy_axi_rd_mst #(
    parameter int ID_W    = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [7:0]          cfg_len,
    input  logic [15:0]         cfg_num,
    output logic                busy,
    output logic                done,
    output logic [3:0]          err,
    easy_axi_rd_mst_if.master   axi,
    output logic                dout_vld,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_last
);
    localparam int               BYTES   = DATA_W / 8;
    localparam logic [2:0]       SIZE    = 3'($clog2(BYTES));
    localparam int               PTR_W   = (MAX_OST > 1) ? $clog2(MAX_OST) : 1;
    localparam int               CNT_W   = $clog2(MAX_OST + 1);
    localparam logic [CNT_W-1:0] OST_MAX = CNT_W'(MAX_OST);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    logic [15:0]       num_q;
    logic [15:0]       issued;
    logic [ID_W-1:0]   fifo_id  [MAX_OST];
    logic [7:0]        fifo_len [MAX_OST];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [7:0]        beat;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == MAX_OST - 1) ? '0 : p + 1'b1;
    endfunction

    // Bursts are in-order, so the FIFO head always describes the beat on R.
    logic              ar_hs, r_hs, r_exp, r_end, beat_is_last, start_ok;
    logic [ID_W-1:0]   head_id;
    logic [7:0]        head_len;
    logic [15:0]       issued_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [ADDR_W-1:0] stride;
    logic [3:0]        err_new;

    assign ar_hs        = axi.arvalid & axi.arready;
    assign r_hs         = axi.rvalid & axi.rready;
    assign r_exp        = r_hs & (count != '0);
    assign head_id      = fifo_id[rd_ptr];
    assign head_len     = fifo_len[rd_ptr];
    assign beat_is_last = (beat == head_len);
    assign r_end        = r_exp & beat_is_last;
    assign start_ok     = start & (state == IDLE);
    assign issued_nxt   = issued + 16'(ar_hs);
    // A push and a final-beat pop in the same cycle cancel out.
    assign count_nxt    = count + CNT_W'(ar_hs) - CNT_W'(r_end);
    assign stride       = (ADDR_W'(axi.arlen) + ADDR_W'(1)) * ADDR_W'(BYTES);
    assign err_new      = {r_hs & (count == '0),
                           r_exp & (axi.rlast != beat_is_last),
                           r_exp & (axi.rid != head_id),
                           r_exp & (axi.rresp != 2'b00)};

    assign axi.rready  = 1'b1;
    assign axi.arsize  = SIZE;
    assign axi.arburst = 2'b01;

    // Run control FSM with registered busy/done and AR channel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register here uses <= so all state updates see the same pre-edge values.
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            num_q       <= '0;
            issued      <= '0;
            axi.arvalid <= 1'b0;
            axi.arid    <= '0;
            axi.araddr  <= '0;
            axi.arlen   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        num_q       <= cfg_num;
                        issued      <= '0;
                        axi.arid    <= '0;
                        axi.araddr  <= cfg_base;
                        axi.arlen   <= cfg_len;
                        axi.arvalid <= (cfg_num != 16'd0);
                    end
                end
                RUN: begin
                    if (ar_hs) begin
                        issued     <= issued_nxt;
                        axi.arid   <= axi.arid + 1'b1;
                        axi.araddr <= axi.araddr + stride;
                    end
                    if (issued == num_q && count == '0) begin
                        state       <= FIN;
                        done        <= 1'b1;
                        axi.arvalid <= 1'b0;
                    end else begin
                        axi.arvalid <= (issued_nxt < num_q) && (count_nxt < OST_MAX);
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Expectation FIFO of issued bursts and the per-burst beat counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is only MAX_OST small entries, so it is cleared like any other register.
            for (int i = 0; i < MAX_OST; i++) begin
                fifo_id[i]  <= '0;
                fifo_len[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            beat   <= '0;
        end else begin
            if (ar_hs) begin
                fifo_id[wr_ptr]  <= axi.arid;
                fifo_len[wr_ptr] <= axi.arlen;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (r_end) begin
                rd_ptr <= ptr_inc(rd_ptr);
                beat   <= '0;
            end else if (r_exp) begin
                beat <= beat + 1'b1;
            end
            count <= count_nxt;
        end
    end

    // Sticky error flags and the registered data sink.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err       <= '0;
            dout_vld  <= 1'b0;
            dout      <= '0;
            dout_last <= 1'b0;
        end else begin
            err      <= (start_ok ? 4'b0000 : err) | err_new;
            dout_vld <= r_exp;
            if (r_exp) begin
                dout      <= axi.rdata;
                dout_last <= beat_is_last;
            end
        end
    end
endmodule

// File: tb/tb_easy_axi_rd_mst.sv
// Self-checking bench for easy_axi_rd_mst: an in-order AXI read slave with
// optional backpressure and fault injection, checked against a burst-level model.
module tb_easy_axi_rd_mst;
    localparam int ID_W    = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAX_OST = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [7:0]        cfg_len;
    logic [15:0]       cfg_num;
    logic              busy, done, dout_vld, dout_last;
    logic [3:0]        err;
    logic [DATA_W-1:0] dout;

    easy_axi_rd_mst_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    easy_axi_rd_mst #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OST(MAX_OST)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_num(cfg_num), .busy(busy), .done(done), .err(err), .axi(axi),
        .dout_vld(dout_vld), .dout(dout), .dout_last(dout_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Burst-level reference state for the current run.
    logic [31:0] run_base;
    int          run_len, run_num;
    int          ar_cnt, done_bursts, beats_fwd, lasts_fwd, beat_total, cur_beat;
    int          pend_k[$];
    logic [3:0]  err_exp;

    // Slave behaviour knobs.
    int          ar_mode;        // 0: always ready, 1: random, 2: never ready
    bit          r_hold, r_rand, stray_req;
    int          inj_resp_beat, inj_last_burst, inj_id_burst;

    // What the slave presented on R before the coming edge.
    bit          drv_rv, drv_exp, drv_last;
    logic [31:0] drv_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe what the edge did, then drive the slave for the next edge.
    task automatic tick();
        logic        p_arv, p_arr;
        logic [31:0] p_addr, e_addr;
        logic [3:0]  p_id;
        logic [7:0]  p_len;
        logic [2:0]  p_size;
        logic [1:0]  p_burst;
        p_arv = axi.arvalid; p_arr = axi.arready; p_addr = axi.araddr; p_id = axi.arid;
        p_len = axi.arlen;   p_size = axi.arsize; p_burst = axi.arburst;
        @(posedge clk);
        #1;
        check("rready", axi.rready, 1);
        if (p_arv && !p_arr) begin
            check("ar_hold_valid", axi.arvalid, 1);
            check("ar_hold_addr", axi.araddr, p_addr);
            check("ar_hold_id", axi.arid, p_id);
        end
        if (p_arv && p_arr) begin
            e_addr = run_base + 32'(ar_cnt * (run_len + 1) * (DATA_W / 8));
            check("araddr", p_addr, e_addr);
            check("arid", p_id, 4'(ar_cnt % 16));
            check("arlen", p_len, 8'(run_len));
            check("arsize", p_size, 2);
            check("arburst", p_burst, 1);
            check("ar_outstanding_lt_max", (ar_cnt - done_bursts) < MAX_OST, 1);
            check("ar_within_num", ar_cnt < run_num, 1);
            pend_k.push_back(ar_cnt);
            ar_cnt++;
        end
        check("dout_vld", dout_vld, drv_rv && drv_exp);
        if (drv_rv && drv_exp) begin
            check("dout", dout, drv_data);
            check("dout_last", dout_last, drv_last);
            beats_fwd++;
            beat_total++;
            if (drv_last) begin
                lasts_fwd++;
                void'(pend_k.pop_front());
                cur_beat = 0;
                done_bursts++;
            end else begin
                cur_beat++;
            end
        end
        drv_rv = 0; drv_exp = 0;
        case (ar_mode)
            0:       axi.arready = 1'b1;
            1:       axi.arready = 1'($urandom_range(0, 1));
            default: axi.arready = 1'b0;
        endcase
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        if (r_hold || pend_k.size() == 0) begin
            if (stray_req && pend_k.size() == 0) begin
                axi.rvalid = 1'b1; axi.rid = '0; axi.rdata = $urandom;
                drv_rv = 1; drv_exp = 0; stray_req = 0;
            end
        end else if (!(r_rand && $urandom_range(0, 3) == 0)) begin
            axi.rvalid = 1'b1;
            axi.rid    = (pend_k[0] == inj_id_burst) ? 4'd5 : 4'(pend_k[0] % 16);
            axi.rdata  = $urandom;
            axi.rresp  = (beat_total == inj_resp_beat) ? 2'b10 : 2'b00;
            drv_last   = (cur_beat == run_len);
            axi.rlast  = (pend_k[0] == inj_last_burst) ? (cur_beat == 2) : drv_last;
            drv_rv = 1; drv_exp = 1; drv_data = axi.rdata;
        end
    endtask

    task automatic start_run(input logic [31:0] base, input int len, input int num);
        run_base = base; run_len = len; run_num = num;
        ar_cnt = 0; done_bursts = 0; beats_fwd = 0; lasts_fwd = 0; beat_total = 0; cur_beat = 0;
        cfg_base = base; cfg_len = 8'(len); cfg_num = 16'(num); start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_clear", err, 0);
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit seen;
        n = 0; seen = 0;
        while (!seen && n < budget) begin
            tick();
            n++;
            check("run_busy", busy, 1);
            if (done === 1'b1) seen = 1;
        end
        check("done_seen", seen, 1);
        if (seen) begin
            check("done_ar_count", ar_cnt, run_num);
            check("done_bursts", done_bursts, run_num);
            check("done_beats", beats_fwd, run_num * (run_len + 1));
            check("done_lasts", lasts_fwd, run_num);
            check("done_err", err, err_exp);
            tick();
            check("done_one_cycle", done, 0);
            check("idle_busy", busy, 0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a0;
        logic [3:0]  i0;
        int          len, num;

        rst_n = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_num = '0;
        axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
        axi.rresp = '0; axi.rlast = 1'b0;
        run_base = '0; run_len = 0; run_num = 0; err_exp = '0;
        ar_cnt = 0; done_bursts = 0; beats_fwd = 0; lasts_fwd = 0; beat_total = 0; cur_beat = 0;
        ar_mode = 0; r_hold = 0; r_rand = 0; stray_req = 0;
        inj_resp_beat = -1; inj_last_burst = -1; inj_id_burst = -1;
        drv_rv = 0; drv_exp = 0; drv_last = 0; drv_data = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_arid", axi.arid, 0);
        check("rst_arlen", axi.arlen, 0);
        check("rst_arsize", axi.arsize, 2);
        check("rst_arburst", axi.arburst, 1);
        check("rst_rready", axi.rready, 1);
        check("rst_err", err, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_dout_last", dout_last, 0);
        check("rst_dout", dout, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_idle", busy, 0);

        // Basic run: 0x1000, 4-beat bursts, two of them.
        start_run(32'h1000, 3, 2);
        wait_done(100);

        // Address wrap at the top of the address space.
        start_run(32'hFFFF_FFF0, 3, 3);
        wait_done(100);

        // Randomized runs with random AR/R backpressure.
        for (int i = 0; i < 8; i++) begin
            ar_mode = $urandom_range(0, 1);
            r_rand  = 1'($urandom_range(0, 1));
            len     = $urandom_range(0, 7);
            num     = $urandom_range(1, 9);
            start_run($urandom, len, num);
            wait_done(num * (len + 1) * 8 + 200);
        end
        ar_mode = 0; r_rand = 0;

        // Outstanding limit with R withheld; a start mid-run must be ignored.
        r_hold = 1;
        start_run(32'h5000, 1, 6);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                cfg_base = 32'hDEAD_0000; cfg_len = 8'd9; cfg_num = 16'd1; start = 1'b1;
            end
            tick();
            start = 1'b0;
        end
        check("ost_ar_count", ar_cnt, MAX_OST);
        check("ost_arvalid_low", axi.arvalid, 0);
        r_hold = 0;
        for (int i = 0; i < 20 && done_bursts == 0; i++) begin
            check("ost_wait_first_last", axi.arvalid, 0);
            tick();
        end
        wait_done(200);

        // AR backpressure: fields frozen for 5 cycles of arready=0.
        ar_mode = 2;
        start_run(32'h4000, 1, 2);
        check("bp_arvalid", axi.arvalid, 1);
        a0 = axi.araddr;
        i0 = axi.arid;
        check("bp_first_addr", a0, 32'h4000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", axi.arvalid, 1);
            check("bp_hold_addr", axi.araddr, a0);
            check("bp_hold_id", axi.arid, i0);
        end
        ar_mode = 0;
        wait_done(100);

        // Error injection: bad rresp, early rlast, wrong rid, then a stray beat in IDLE.
        inj_resp_beat = 1; inj_last_burst = 0; inj_id_burst = 1;
        err_exp = 4'b0111;
        start_run(32'h2000, 3, 3);
        wait_done(100);
        inj_resp_beat = -1; inj_last_burst = -1; inj_id_burst = -1;
        stray_req = 1;
        tick();
        tick();
        check("err_all", err, 4'b1111);
        check("err_idle_busy", busy, 0);
        err_exp = 4'b0000;
        start_run(32'h2100, 0, 1);
        wait_done(50);

        // Zero bursts: done two cycles after start, never arvalid.
        start_run(32'h3000, 2, 0);
        check("zero_arvalid_0", axi.arvalid, 0);
        check("zero_done_0", done, 0);
        tick();
        check("zero_done_1", done, 1);
        check("zero_busy_1", busy, 1);
        check("zero_arvalid_1", axi.arvalid, 0);
        tick();
        check("zero_done_2", done, 0);
        check("zero_busy_2", busy, 0);

        // Mid-run reset.
        ar_mode = 1; r_rand = 1;
        start_run(32'h6000, 7, 8);
        repeat (12) tick();
        rst_n = 1'b0;
        #1;
        check("mrst_arvalid", axi.arvalid, 0);
        check("mrst_busy", busy, 0);
        check("mrst_dout_vld", dout_vld, 0);
        check("mrst_araddr", axi.araddr, 0);
        check("mrst_err", err, 0);
        pend_k.delete();
        cur_beat = 0; drv_rv = 0; drv_exp = 0;
        axi.rvalid = 1'b0; ar_mode = 0; r_rand = 0;
        run_num = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mrst_quiet_busy", busy, 0);
            check("mrst_quiet_arvalid", axi.arvalid, 0);
        end
        start_run(32'h1000, 3, 2);
        wait_done(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/easy_axi_rd_mst.md
EASY_AXI_RD_MST -- requirements
Module: easy_axi_rd_mst

Interface
REQ-001 SHALL provide parameter ID_W, default 4: AXI ID width.
REQ-002 SHALL provide parameter ADDR_W, default 32: address width.
REQ-003 SHALL provide parameter DATA_W, default 32: data width; legal values 32, 64, 128.
REQ-004 SHALL provide parameter MAX_OST, default 4: maximum outstanding bursts; power of 2, at most 2^ID_W.
REQ-005 SHALL use a single clock; reset is asynchronous, active-low.
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
REQ-006 SHALL provide the following control and status ports:
- start  in  1  launches a run.
- cfg_base  in  ADDR_W  first burst address.
- cfg_len  in  8  ARLEN for every burst.
- cfg_num  in  16  number of bursts.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  4  sticky errors: [0] rresp!=OKAY, [1] rid mismatch, [2] rlast misplaced, [3] unexpected beat.
REQ-007 SHALL provide the AR channel: arvalid out 1; arready in 1; arid out ID_W; araddr out ADDR_W; arlen out 8; arsize out 3; arburst out 2.
REQ-008 SHALL provide the R channel: rvalid in 1; rready out 1; rid in ID_W; rdata in DATA_W; rresp in 2; rlast in 1.
REQ-009 SHALL provide the data sink: dout_vld out 1; dout out DATA_W; dout_last out 1.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and FIN.
- IDLE->RUN on start.
- RUN->FIN when issued==cfg_num and outstanding==0.
- FIN->IDLE unconditionally after one cycle.
REQ-011 SHALL latch cfg_base/cfg_len/cfg_num on start in IDLE, clear err, and zero the issue counter; start outside IDLE SHALL be ignored.
REQ-012 SHALL take IDLE->RUN->FIN->IDLE when cfg_num==0, with no AR issued.
REQ-013 SHALL assert busy in RUN and FIN, and assert done only in FIN.
REQ-014 SHALL assert arvalid in RUN while issued<cfg_num and outstanding<MAX_OST.
REQ-015 SHALL hold all AR fields stable while arvalid=1 and arready=0.
REQ-016 SHALL never deassert arvalid before handshake.
REQ-017 SHALL drive AR fields as follows:
- Burst k (0-based) uses arid = k mod 2^ID_W.
- araddr = cfg_base + k*(cfg_len+1)*(DATA_W/8), modulo 2^ADDR_W.
- arlen = cfg_len.
- arsize = log2(DATA_W/8).
- arburst = 2'b01 (INCR).
REQ-018 SHALL push {arid, arlen} into an expectation FIFO of depth MAX_OST on each AR handshake.
REQ-019 SHALL track outstanding = FIFO occupancy.
REQ-020 SHALL leave outstanding unchanged when an AR handshake and a last R beat occur in the same cycle.
REQ-021 SHALL hold rready=1 in every state.
REQ-022 SHALL count beats per burst from 0 on each R handshake with a non-empty FIFO.
REQ-023 SHALL set err[0] when rresp!=0.
REQ-024 SHALL set err[1] when rid != FIFO head id.
REQ-025 SHALL set err[2] when rlast != (beat==head len).
REQ-026 SHALL pop the FIFO and reset the beat count when beat==head len, regardless of rlast.
REQ-027 SHALL handle an R handshake with an empty FIFO as follows: set err[3], do not forward the beat, leave counters unchanged.
REQ-028 SHALL register each accepted expected beat to dout/dout_last with dout_vld=1 exactly one cycle after the handshake.
REQ-029 SHALL keep dout_last = 1 on the final beat of each burst.
REQ-030 SHALL keep err bits sticky until the next accepted start.

Reset
REQ-031 SHALL drive the following on rst_n low, at any time including mid-run:
- FSM to IDLE.
- arvalid, busy, done, dout_vld, dout_last to 0.
- arid, araddr, arlen to 0.
- arsize to log2(DATA_W/8), arburst to 2'b01.
- err, FIFO, counters and dout to 0.
- rready to 1.
REQ-032 SHALL keep all state reset while rst_n is low; after release, operation SHALL resume only on a new start.

Verification
REQ-033 SHALL cover a basic run:
- Stimulus: base=0x1000, len=3, num=2, DATA_W=32, arready=1, in-order OKAY slave.
- Response: araddr 0x1000 then 0x1010; arid 0,1; 8 dout_vld beats; dout_last on beats 4 and 8; done pulse; err=0.
REQ-034 SHALL cover outstanding limit:
- Stimulus: MAX_OST=4, num=6, R withheld.
- Response: exactly 4 AR handshakes, then arvalid=0 until the first burst's last beat is accepted.
REQ-035 SHALL cover arready backpressure:
- Stimulus: arready=0 for 5 cycles.
- Response: arvalid held at 1 with araddr/arid unchanged across all 5 cycles.
REQ-036 SHALL cover error injection:
- Stimulus: rresp=2 on one beat; rlast early on beat 2 of len=3; rid=5 when 1 is expected; stray R beat in IDLE.
- Response: err=4'b1111 after the run; err cleared on the next start.
REQ-037 SHALL cover zero-burst and mid-run reset:
- Stimulus: num=0; separately, rst_n pulsed low mid-run.
- Response: num=0 gives done 2 cycles after start with no arvalid; mid-run reset drives arvalid=0 and busy=0 immediately, with no activity until the next start.
